dram_slave: RTL and testbench

Parametrised data-RAM slave on the shared data bus (MADDR/MDATA/MBE/MEN/MRW/MWAIT). It replaces the fixed 64 KiB, one-wait-state data RAM with a block whose base address, depth and read latency are parameters. Writes complete with zero wait states and per-byte enables. Reads insert exactly READ_LAT wait states. An optional checker rejects illegal byte-enable patterns. Multiple instances at disjoint bases share the bus through tri-stated MDATA and MWAIT.

---
 rtl/dram_slave.sv | 120 ++++++++++++
 tb/tb_dram_slave.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_slave.sv
// dram_slave: parametrised data-RAM slave on the shared MADDR/MDATA/MBE bus.
// Zero-wait byte-enabled writes, reads with READ_LAT wait states, tri-stated
// MDATA/MWAIT so several instances can sit at disjoint base addresses.
// Optional byte-enable legality checker: define DRAM_SLAVE_BE_CHECK_EN.
module dram_slave #(
    parameter logic [31:0] BASE     = 32'h0003_0000,
    parameter int          ADDR_W   = 14,
    parameter int          READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MADDR,
    inout  wire  [31:0] MDATA,
    input  logic [3:0]  MBE,
    input  logic        MEN,
    input  logic        MRW,
    output logic        MWAIT,
    output logic        MERR
);

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [2:0] LAT    = 3'(READ_LAT);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [31:0]       mem [DEPTH];
    logic              sel, rd_sel, wr_sel, be_ok, mwait_int;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_out;
    logic [0:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              unused_addr;

    assign sel         = MEN && (MADDR[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    assign rd_sel      = sel && !MRW;
    assign wr_sel      = sel && MRW;
    assign idx         = MADDR[ADDR_W+1:2];
    assign unused_addr = ^MADDR[1:0];

    // Read FSM: count wait states; any drop of the read request returns to IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mwait_int = 1'b0;
        if (!rd_sel || READ_LAT == 0) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end else if (state_q == S_IDLE) begin
            mwait_int = 1'b1;
            state_d   = S_WAIT;
            cnt_d     = 3'd1;
        end else if (cnt_q == LAT) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end else begin
            mwait_int = 1'b1;
            cnt_d     = cnt_q + 3'd1;
        end
    end

    // Read register tracks the array on every selected read cycle, including the
    // request cycle, so it already holds the word when the DONE cycle arrives
    // (needed for READ_LAT = 1, where DONE is the first WAIT cycle).
    always_comb begin
        rdata_d = rd_sel ? mem[idx] : rdata_q;
    end

    // FSM and read register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM array write port: per-lane byte enables, contents never reset.
    always_ff @(posedge clk) begin
        if (wr_sel && be_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (MBE[b]) mem[idx][8*b +: 8] <= MDATA[8*b +: 8];
            end
        end
    end

`ifdef DRAM_SLAVE_BE_CHECK_EN
    logic merr_q, merr_d;

    // Legal patterns: single byte, aligned halfword, full word, or none.
    always_comb begin
        case (MBE)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
            default:                   be_ok = 1'b0;
        endcase
        merr_d = wr_sel && !be_ok;
    end

    // MERR is a one-cycle registered pulse after the rejected write edge.
    always_ff @(posedge clk) begin
        if (rst) merr_q <= 1'b0;
        else     merr_q <= merr_d;
    end

    assign MERR = merr_q;
`else
    assign be_ok = 1'b1;
    assign MERR  = 1'b0;
`endif

    assign rd_out = (READ_LAT == 0) ? mem[idx] : rdata_q;
    assign MDATA  = rd_sel ? rd_out : 32'hzzzz_zzzz;
    assign MWAIT  = sel ? mwait_int : 1'bz;

endmodule

// File: tb/tb_dram_slave.sv
// tb_dram_slave: three dram_slave instances on one bus (READ_LAT 1, 3, 0).
module tb_dram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] maddr = 32'd0;
    logic [31:0] wdat  = 32'd0;
    logic [3:0]  mbe   = 4'd0;
    logic        men   = 1'b0;
    logic        mrw   = 1'b0;

    wire  [31:0] mdata_a, mdata_b, mdata_c;
    wire         mwait_a, mwait_b, mwait_c;
    wire         merr_a, merr_b, merr_c;

    always #5 clk = ~clk;

    pulldown (mwait_a);

    assign mdata_a = (men && mrw) ? wdat : 32'hzzzz_zzzz;
    assign mdata_b = (men && mrw) ? wdat : 32'hzzzz_zzzz;
    assign mdata_c = (men && mrw) ? wdat : 32'hzzzz_zzzz;

    dram_slave #(.BASE(32'h0003_0000), .ADDR_W(14), .READ_LAT(1)) u_a (
        .clk(clk), .rst(rst), .MADDR(maddr), .MDATA(mdata_a), .MBE(mbe),
        .MEN(men), .MRW(mrw), .MWAIT(mwait_a), .MERR(merr_a));
    dram_slave #(.BASE(32'h0005_0000), .ADDR_W(14), .READ_LAT(3)) u_b (
        .clk(clk), .rst(rst), .MADDR(maddr), .MDATA(mdata_b), .MBE(mbe),
        .MEN(men), .MRW(mrw), .MWAIT(mwait_b), .MERR(merr_b));
    dram_slave #(.BASE(32'h0006_0000), .ADDR_W(14), .READ_LAT(0)) u_c (
        .clk(clk), .rst(rst), .MADDR(maddr), .MDATA(mdata_c), .MBE(mbe),
        .MEN(men), .MRW(mrw), .MWAIT(mwait_c), .MERR(merr_c));

    typedef struct {
        logic        rw;    // 1 = write
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;  // write data, or expected read data
        int          cyc;   // expected transfer length in cycles
    } vec_t;

    typedef struct {
        logic        rw;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    vec_t tbl[16];
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic pick_wait(input logic [31:0] a);
        case (a[31:16])
            16'h0005: return mwait_b;
            16'h0006: return mwait_c;
            default:  return mwait_a;
        endcase
    endfunction

    function automatic logic [31:0] pick_data(input logic [31:0] a);
        case (a[31:16])
            16'h0005: return mdata_b;
            16'h0006: return mdata_c;
            default:  return mdata_a;
        endcase
    endfunction

    // Drive one transfer (called #1 after a rising edge), wait for MWAIT = 0,
    // then score it against the entry queued when it was driven.
    task automatic run(input vec_t v, input string tag);
        exp_t        e;
        logic        done;
        logic [31:0] got;
        int          cyc;
        men = 1'b1; mrw = v.rw; maddr = v.addr; mbe = v.be;
        wdat = v.rw ? v.data : 32'h0;
        e.rw = v.rw; e.data = v.data; e.cyc = v.cyc;
        sbq.push_back(e);
        done = 1'b0; got = 32'h0; cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (pick_wait(v.addr) === 1'b0) begin
                done = 1'b1;
                got  = pick_data(v.addr);
            end
            @(posedge clk); #1;
        end
        e = sbq.pop_front();
        if (!done) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_cycles"}, 32'(cyc), 32'(e.cyc));
            if (!e.rw) chk({tag, "_rdata"}, got, e.data);
        end
    endtask

    task automatic idle();
        men = 1'b0; mrw = 1'b0; mbe = 4'd0;
        @(posedge clk); #1;
    endtask

    logic        seq_exp [8];
    logic [31:0] be_exp;
    logic        merr_exp;

    initial begin
        tbl[0]  = '{1'b1, 32'h0003_0010, 4'hF, 32'hDEAD_BEEF, 1};
        tbl[1]  = '{1'b0, 32'h0003_0010, 4'h0, 32'hDEAD_BEEF, 2};
        tbl[2]  = '{1'b1, 32'h0003_0020, 4'hF, 32'h1122_3344, 1};
        tbl[3]  = '{1'b1, 32'h0003_0020, 4'h4, 32'hAABB_CCDD, 1};
        tbl[4]  = '{1'b0, 32'h0003_0020, 4'hF, 32'h11BB_3344, 2};
        tbl[5]  = '{1'b1, 32'h0003_FFFC, 4'hF, 32'hCAFE_F00D, 1};
        tbl[6]  = '{1'b0, 32'h0003_FFFC, 4'h0, 32'hCAFE_F00D, 2};
        tbl[7]  = '{1'b1, 32'h0003_0000, 4'hF, 32'h0102_0304, 1};
        tbl[8]  = '{1'b1, 32'h0003_0000, 4'h0, 32'hFFFF_FFFF, 1};
        tbl[9]  = '{1'b0, 32'h0003_0000, 4'h0, 32'h0102_0304, 2};
        tbl[10] = '{1'b1, 32'h0003_0000, 4'h3, 32'hA5A5_A5A5, 1};
        tbl[11] = '{1'b0, 32'h0003_0013, 4'h0, 32'hDEAD_BEEF, 2};
        tbl[12] = '{1'b1, 32'h0005_0004, 4'hF, 32'h1234_5678, 1};
        tbl[13] = '{1'b0, 32'h0005_0004, 4'h0, 32'h1234_5678, 4};
        tbl[14] = '{1'b1, 32'h0006_0008, 4'hF, 32'h5A5A_0FF0, 1};
        tbl[15] = '{1'b0, 32'h0006_0008, 4'h0, 32'h5A5A_0FF0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_merr", {31'd0, merr_a}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        men = 1'b1; mrw = 1'b0; maddr = 32'h0005_0010;
        @(negedge clk);
        chk("rst_rdata", mdata_b, 32'd0);
        chk("rst_wait", {31'd0, mwait_b}, 32'd1);
        @(posedge clk); #1;
        idle();

        // Table: back-to-back transfers across all three windows
        for (int i = 0; i < 16; i++) run(tbl[i], $sformatf("vec%0d", i));
        run('{1'b0, 32'h0003_0000, 4'h0, 32'h0102_A5A5, 2}, "be0011");

        // READ_LAT = 3, read held across two transfers
        seq_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        men = 1'b1; mrw = 1'b0; maddr = 32'h0005_0004;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_wait%0d", i), {31'd0, mwait_b}, {31'd0, seq_exp[i]});
            if (i == 3 || i == 7) chk($sformatf("b2b_data%0d", i), mdata_b, 32'h1234_5678);
            @(posedge clk); #1;
        end
        idle();

        // Reset pulsed during WAIT: latency restarts in full
        seq_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        men = 1'b1; mrw = 1'b0; maddr = 32'h0005_0004;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rstw_wait%0d", i), {31'd0, mwait_b}, {31'd0, seq_exp[i]});
            if (i == 5) chk("rstw_data", mdata_b, 32'h1234_5678);
            @(posedge clk); #1;
            rst = (i == 0);
        end
        rst = 1'b0;
        idle();

        // Deselected window (just past A's top): no drive, no write
        men = 1'b1; mrw = 1'b1; maddr = 32'h0004_0000; mbe = 4'hF; wdat = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("desel_wr_wait", {31'd0, mwait_a}, 32'd0);
        @(posedge clk); #1;
        mrw = 1'b0;
        @(negedge clk);
        chk("desel_rd_wait", {31'd0, mwait_a}, 32'd0);
        @(posedge clk); #1;
        run('{1'b0, 32'h0003_0000, 4'h0, 32'h0102_A5A5, 2}, "desel_ram");

        // Illegal byte-enable pattern 0101
`ifdef DRAM_SLAVE_BE_CHECK_EN
        be_exp = 32'h1111_1111; merr_exp = 1'b1;
`else
        be_exp = 32'h1122_1122; merr_exp = 1'b0;
`endif
        run('{1'b1, 32'h0003_0040, 4'hF, 32'h1111_1111, 1}, "be_init");
        men = 1'b1; mrw = 1'b1; maddr = 32'h0003_0040; mbe = 4'b0101; wdat = 32'h2222_2222;
        @(negedge clk);
        chk("be_wait", {31'd0, mwait_a}, 32'd0);
        @(posedge clk); #1;
        men = 1'b0;
        @(negedge clk);
        chk("be_merr", {31'd0, merr_a}, {31'd0, merr_exp});
        @(posedge clk); #1;
        @(negedge clk);
        chk("be_merr_clr", {31'd0, merr_a}, 32'd0);
        @(posedge clk); #1;
        run('{1'b0, 32'h0003_0040, 4'h0, be_exp, 2}, "be_rd");
        chk("rd_merr", {31'd0, merr_a}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
